// File: rtl/dmem_ctrl.sv
// Load/store backend: valid/ready request/response, programmable wait states,
// byte-lane RAM, alignment/decode faults and an MMIO window (LED register, 64-bit cycle counter).
module dmem_ctrl #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LED_WIDTH   = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic [LED_WIDTH-1:0] leds_out
);

  localparam int          BYTES     = XLEN / 8;
  localparam int          OFFW      = $clog2(BYTES);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS * BYTES);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wcnt;
  logic [63:0]           cnt;
  logic [XLEN-1:0]       mem [DEPTH_WORDS];

  logic [OFFW-1:0]       off;
  logic [AW-1:0]         widx;
  logic                  accept, legal, misal, is_ram, is_led, is_clo, is_chi, fault;
  logic [BYTES-1:0]      be;
  logic [XLEN-1:0]       wdata_sh, rdata_sel;

  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] word,
                                               input logic [2:0] f3,
                                               input logic [OFFW-1:0] o);
    logic [XLEN-1:0] sh;
    sh = word >> {o, 3'b000};
    case (f3)
      3'b000:  load_fmt = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b100:  load_fmt = XLEN'(sh[7:0]);
      3'b001:  load_fmt = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b101:  load_fmt = XLEN'(sh[15:0]);
      default: load_fmt = sh;
    endcase
  endfunction

  function automatic logic [BYTES-1:0] byte_en(input logic [1:0] size, input logic [OFFW-1:0] o);
    case (size)
      2'd0:    byte_en = BYTES'(1) << o;
      2'd1:    byte_en = BYTES'(3) << o;
      default: byte_en = '1;
    endcase
  endfunction

  assign off      = req_addr[OFFW-1:0];
  assign widx     = req_addr[AW+OFFW-1:OFFW];
  assign accept   = (state == S_IDLE) && req_valid;
  assign be       = byte_en(req_funct3[1:0], off);
  assign wdata_sh = req_wdata << {off, 3'b000};

  // Decode and fault detection for the request currently on the bus
  always_comb begin
    legal  = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                    : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal  = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
             ((req_funct3[1:0] == 2'd2) && (off != '0));
    is_ram = {1'b0, req_addr} < RAM_LIMIT;
    is_led = req_addr == MMIO_BASE;
    is_clo = req_addr == MMIO_BASE + 32'h4;
    is_chi = req_addr == MMIO_BASE + 32'h8;
    fault  = !legal || misal ||
             !(is_ram || ((is_led || is_clo || is_chi) && (req_funct3 == 3'b010)));
  end

  always_comb begin
    rdata_sel = '0;
    if (is_ram)      rdata_sel = load_fmt(mem[widx], req_funct3, off);
    else if (is_led) rdata_sel = XLEN'(leds_out);
    else if (is_clo) rdata_sel = XLEN'(cnt[31:0]);
    else if (is_chi) rdata_sel = XLEN'(cnt[63:32]);
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !fault && is_ram)
      for (int b = 0; b < BYTES; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wcnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // Payload, side effects and counter sampling all commit at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= 4'd0;
      cnt       <= 64'd0;
      leds_out  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cnt <= cnt + 64'd1;
      if (accept) begin
        wcnt      <= WAIT_LOAD;
        rsp_err   <= fault;
        rsp_rdata <= (fault || req_we) ? '0 : rdata_sel;
        if (req_we && !fault && is_led) leds_out <= req_wdata[LED_WIDTH-1:0];
      end else if ((state == S_WAIT) && (wcnt != 4'd0)) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

endmodule
